// File: rtl/cpu_accel_pkg.sv
// Shared defaults for the CPU/accelerator FIFO bridge.
`default_nettype none
package cpu_accel_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_ACCEL_ID_WIDTH = 4;

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; refuses push when full and pop when empty.
`default_nettype none
module sync_fifo
  import cpu_accel_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is left uninitialised; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_accel_fifo.sv
// CPU-side bridge to one accelerator: TX FIFO towards it, RX FIFO from it, sticky error flag.
`default_nettype none
module cpu_accel_fifo
  import cpu_accel_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int DEPTH          = 8,
  parameter int ACCEL_ID_WIDTH = DEFAULT_ACCEL_ID_WIDTH,
  parameter int ACCEL_ID       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ACCEL_ID_WIDTH-1:0] accel_id,
  output logic                      accel_can_read,
  output logic                      accel_can_write,
  input  logic                      accel_read_enable,
  output logic [DATA_WIDTH-1:0]     accel_read_data,
  input  logic                      accel_write_enable,
  input  logic [DATA_WIDTH-1:0]     accel_write_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      error
);

  logic                  sel;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  rx_full;
  logic                  rx_empty;
  logic [DATA_WIDTH-1:0] rx_head;

  assign sel = (accel_id == ACCEL_ID_WIDTH'(ACCEL_ID));

  // Full/empty checks live inside the FIFOs, so requests are passed through ungated.
  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sel && accel_write_enable),
    .push_data (accel_write_data),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (sel && accel_read_enable),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign tx_valid        = !tx_empty;
  assign rx_ready        = !rx_full;
  assign accel_can_read  = sel && !rx_empty;
  assign accel_can_write = sel && !tx_full;
  assign accel_read_data = sel ? rx_head : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (sel && ((accel_write_enable && tx_full) ||
                         (accel_read_enable && rx_empty))) begin
      error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_accel_fifo.sv
// Directed bench for cpu_accel_fifo against a queue-based reference model.
`default_nettype none
module tb_cpu_accel_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int IDW   = 4;
  localparam int AID   = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDW-1:0] accel_id = IDW'(AID);
  logic           accel_can_read, accel_can_write;
  logic           accel_read_enable = 1'b0;
  logic [DW-1:0]  accel_read_data;
  logic           accel_write_enable = 1'b0;
  logic [DW-1:0]  accel_write_data = '0;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [DW-1:0]  tx_data;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic [DW-1:0]  rx_data = '0;
  logic           error;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  cpu_accel_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ACCEL_ID_WIDTH(IDW), .ACCEL_ID(AID)
  ) dut (
    .clk(clk), .rst(rst), .accel_id(accel_id),
    .accel_can_read(accel_can_read), .accel_can_write(accel_can_write),
    .accel_read_enable(accel_read_enable), .accel_read_data(accel_read_data),
    .accel_write_enable(accel_write_enable), .accel_write_data(accel_write_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: two word queues and a sticky error bit.
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  bit            merr = 1'b0;
  bit            m_sel, m_txpush, m_txpop, m_rxpush, m_rxpop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      txq.delete();
      rxq.delete();
      merr = 1'b0;
    end else begin
      m_sel    = (accel_id == IDW'(AID));
      m_txpush = m_sel && accel_write_enable && (txq.size() < DEPTH);
      m_txpop  = tx_ready && (txq.size() > 0);
      m_rxpush = rx_valid && (rxq.size() < DEPTH);
      m_rxpop  = m_sel && accel_read_enable && (rxq.size() > 0);
      if (m_sel && ((accel_write_enable && txq.size() == DEPTH) ||
                    (accel_read_enable && rxq.size() == 0)))
        merr = 1'b1;
      if (m_txpop) void'(txq.pop_front());
      if (m_txpush) txq.push_back(accel_write_data);
      if (m_rxpop) void'(rxq.pop_front());
      if (m_rxpush) rxq.push_back(rx_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      m_sel = (accel_id == IDW'(AID));
      chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
      chk("tx_data", 32'(tx_data), (txq.size() != 0) ? 32'(txq[0]) : 32'd0);
      chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < DEPTH));
      chk("can_read", 32'(accel_can_read), 32'(m_sel && rxq.size() != 0));
      chk("read_data", 32'(accel_read_data),
          (m_sel && rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
      chk("can_write", 32'(accel_can_write), 32'(m_sel && txq.size() < DEPTH));
      chk("error", 32'(error), 32'(merr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    #2;
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 started = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_can_read", 32'(accel_can_read), 32'd0);
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);
    chk("reset_can_write", 32'(accel_can_write), 32'd1);
    chk("reset_error", 32'(error), 32'd0);

    // Three writes held back, then streamed out.
    for (int i = 1; i <= 3; i++) begin
      accel_write_enable = 1'b1; accel_write_data = DW'(i); cyc();
    end
    accel_write_enable = 1'b0;
    chk("t1_valid", 32'(tx_valid), 32'd1);
    chk("t1_head", 32'(tx_data), 32'd1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("t1_stream", 32'(tx_data), 32'(i));
      cyc();
    end
    chk("t1_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Overfill: ninth write dropped and flagged; full+pop still refuses the push.
    for (int i = 1; i <= 8; i++) begin
      accel_write_enable = 1'b1; accel_write_data = DW'(i); cyc();
    end
    chk("t2_full_can_write", 32'(accel_can_write), 32'd0);
    accel_write_data = DW'(9); cyc();
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_head", 32'(tx_data), 32'd1);
    accel_write_data = DW'(99); tx_ready = 1'b1; cyc();
    accel_write_enable = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      chk("t2_drain", 32'(tx_data), 32'(i));
      cyc();
    end
    chk("t2_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // Single RX word delivered to the CPU.
    rx_valid = 1'b1; rx_data = DW'(42); cyc();
    rx_valid = 1'b0;
    chk("t3_can_read", 32'(accel_can_read), 32'd1);
    chk("t3_data", 32'(accel_read_data), 32'd42);
    accel_read_enable = 1'b1; cyc();
    accel_read_enable = 1'b0;
    chk("t3_after_can_read", 32'(accel_can_read), 32'd0);
    chk("t3_after_data", 32'(accel_read_data), 32'd0);

    // Unselected ID: CPU enables are ignored and no error is raised.
    pulse_reset();
    rx_valid = 1'b1; rx_data = DW'(77); cyc();
    rx_valid = 1'b0;
    accel_id = IDW'(2);
    accel_write_enable = 1'b1; accel_write_data = DW'(55); accel_read_enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("t4_can_read", 32'(accel_can_read), 32'd0);
    chk("t4_can_write", 32'(accel_can_write), 32'd0);
    chk("t4_read_data", 32'(accel_read_data), 32'd0);
    chk("t4_error", 32'(error), 32'd0);
    accel_write_enable = 1'b0; accel_read_enable = 1'b0;
    accel_id = IDW'(AID);
    #1;
    chk("t4_tx_valid", 32'(tx_valid), 32'd0);
    chk("t4_kept_word", 32'(accel_read_data), 32'd77);
    accel_read_enable = 1'b1; cyc();
    accel_read_enable = 1'b0;

    // Count held at 4 on both FIFOs while pointers wrap.
    for (int i = 0; i < 4; i++) begin
      accel_write_enable = 1'b1; accel_write_data = DW'(10 + i);
      rx_valid = 1'b1; rx_data = DW'(110 + i); cyc();
    end
    tx_ready = 1'b1; accel_read_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      accel_write_data = DW'(14 + i); rx_data = DW'(114 + i); cyc();
    end
    accel_write_enable = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_tx_order", 32'(tx_data), 32'(30 + i));
      chk("t5_rx_order", 32'(accel_read_data), 32'(130 + i));
      cyc();
    end
    chk("t5_tx_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0; accel_read_enable = 1'b0;

    // Mid-stream reset discards buffered words.
    for (int i = 0; i < 5; i++) begin
      accel_write_enable = 1'b1; accel_write_data = DW'(20 + i); cyc();
    end
    accel_write_enable = 1'b0;
    pulse_reset();
    accel_write_enable = 1'b1; accel_write_data = DW'(7); cyc();
    accel_write_enable = 1'b0;
    chk("t6_first_after_reset", 32'(tx_data), 32'd7);

    // Read with RX empty raises the sticky error.
    accel_read_enable = 1'b1; cyc();
    accel_read_enable = 1'b0; cyc();
    chk("t7_read_empty_error", 32'(error), 32'd1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_accel_fifo.md
CPU_ACCEL_FIFO -- requirements
Module: cpu_accel_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, accel word width.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; a power of two, at least 2.
REQ-003 SHALL have parameter ACCEL_ID_WIDTH, default 4, width of accel_id.
REQ-004 SHALL have parameter ACCEL_ID, default 0, the ID this block answers to.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port accel_id  in  ACCEL_ID_WIDTH  accelerator selected by the CPU.
REQ-008 SHALL have port accel_can_read  out  1  RX FIFO non-empty and ID matches.
REQ-009 SHALL have port accel_can_write  out  1  TX FIFO not full and ID matches.
REQ-010 SHALL have port accel_read_enable  in  1  CPU pops the RX head.
REQ-011 SHALL have port accel_read_data  out  DATA_WIDTH  RX head word.
REQ-012 SHALL have port accel_write_enable  in  1  CPU pushes accel_write_data.
REQ-013 SHALL have port accel_write_data  in  DATA_WIDTH  word to the accelerator.
REQ-014 SHALL have port tx_valid / tx_ready / tx_data  out / in / out  1 / 1 / DATA_WIDTH  stream to the accelerator.
REQ-015 SHALL have port rx_valid / rx_ready / rx_data  in / out / in  1 / 1 / DATA_WIDTH  stream from the accelerator.
REQ-016 SHALL have port error  out  1  sticky protocol-violation flag.

Function
REQ-017 SHALL define sel = (accel_id == ACCEL_ID); when sel=0, accel_can_read=0, accel_can_write=0, and CPU enables are ignored.
REQ-018 TX push SHALL occur when sel && accel_write_enable && !tx_full; TX pop SHALL occur when tx_valid && tx_ready.
REQ-019 RX push SHALL occur when rx_valid && rx_ready; RX pop SHALL occur when sel && accel_read_enable && accel_can_read.
REQ-020 Each FIFO SHALL be first-word-fall-through: a word pushed at edge N is visible on the head output (tx_data / accel_read_data) and its valid flag from edge N until the edge that pops it.
REQ-021 tx_valid SHALL equal !tx_empty; rx_ready SHALL equal !rx_full; accel_can_read SHALL equal sel && !rx_empty; accel_can_write SHALL equal sel && !tx_full; all are combinational from registered counts and accel_id.
REQ-022 accel_read_data SHALL be 0 whenever accel_can_read=0; tx_data SHALL be 0 whenever tx_valid=0.
REQ-023 Occupancy counters SHALL be $clog2(DEPTH)+1 bits wide; read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Simultaneous push and pop on a non-empty, non-full FIFO SHALL leave the count unchanged and advance both pointers.
REQ-025 When full, a push SHALL be refused even if a pop occurs in the same cycle; readiness is judged on the pre-edge count.
REQ-026 When empty, a pop SHALL be impossible; a push in that cycle becomes the head at the next edge.
REQ-027 error SHALL be set at the edge where sel && ((accel_write_enable && tx_full) || (accel_read_enable && rx_empty)), and SHALL hold until reset.
REQ-028 A refused operation SHALL NOT alter FIFO contents, pointers or counts.

Reset
REQ-029 On rst=1, counts, pointers and error SHALL clear to 0 immediately, so tx_valid=0, accel_can_read=0, rx_ready=1, and accel_can_write=sel.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; storage arrays need not be cleared.

Structure
REQ-031 Default DATA_WIDTH and ACCEL_ID_WIDTH constants SHALL reside in the shared package cpu_accel_pkg.
REQ-032 One sub-module, sync_fifo (parameters DATA_WIDTH and DEPTH; push, pop, head, full, empty), SHALL be instantiated twice, for TX and RX.

Verification
REQ-033 Reset, then CPU writes 1,2,3 with accel_id=ACCEL_ID and tx_ready=0 -> tx_valid=1 and tx_data=1; with tx_ready=1, tx_data is 1,2,3 on consecutive cycles, then tx_valid=0.
REQ-034 DEPTH=8, tx_ready=0, 9 writes -> accel_can_write=0 after the 8th write; the 9th write is dropped and error=1; draining yields exactly words 1..8.
REQ-035 rx_valid=1 with rx_data=42 for one cycle -> accel_can_read=1 and accel_read_data=42; one read_enable -> accel_can_read=0 and accel_read_data=0.
REQ-036 accel_id != ACCEL_ID with writes and reads asserted -> no FIFO change, can_read=can_write=0, error=0.
REQ-037 Continuous push and pop at count 4 for 20 cycles (pointer wrap) -> count stays 4 and data order is preserved.
REQ-038 rst pulsed while TX holds 5 words -> tx_valid=0 immediately; a later write of 7 emerges first on tx_data.
